// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows engine.
// Blocks arrive column-major (k = 4*c + r) and are written into one of two
// 16-byte ping-pong banks. A full bank is read back in permuted order so
// that out[r][c] = in[r][(c - r) mod 4]. One bank can fill while the other
// drains, which sustains one byte per cycle in both directions.
module inv_shift_rows_stream #(
  parameter bit LAST_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       err
);

  logic [7:0] bank_q [2][16];
  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic [3:0] rd_cnt_q, rd_cnt_d;
  logic       err_q, err_d;

  logic       s_fire;
  logic       m_fire;
  logic       frame_err;
  logic       wr_en;
  logic [1:0] src_col;
  logic [3:0] src_idx;

  assign s_ready = ~full_q[wr_bank_q];
  assign m_valid = full_q[rd_bank_q];

  assign s_fire = s_valid & s_ready;
  assign m_fire = m_valid & m_ready;

  // A misplaced or missing s_last only matters when framing is checked.
  assign frame_err = LAST_CHECK & (s_last != (wr_cnt_q == 4'd15));
  assign wr_en     = s_fire & ~frame_err;

  // Output byte (row r, col c) comes from bank byte at column (c - r) mod 4.
  assign src_col = rd_cnt_q[3:2] - rd_cnt_q[1:0];
  assign src_idx = {src_col, rd_cnt_q[1:0]};

  assign m_data = bank_q[rd_bank_q][src_idx];
  assign m_last = m_valid & (rd_cnt_q == 4'd15);
  assign err    = LAST_CHECK ? err_q : 1'b0;

  // Next-state for pointers, counters, full flags and the error pulse.
  // Set and clear of full flags never collide: a bank being written is empty
  // and a bank being read is full.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_d     = 1'b0;

    if (s_fire) begin
      if (frame_err) begin
        wr_cnt_d = 4'd0;
        err_d    = 1'b1;
      end else if (wr_cnt_q == 4'd15) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = 4'd0;
      end else begin
        wr_cnt_d = wr_cnt_q + 4'd1;
      end
    end

    if (m_fire) begin
      if (rd_cnt_q == 4'd15) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_cnt_d          = 4'd0;
      end else begin
        rd_cnt_d = rd_cnt_q + 4'd1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= 4'd0;
      rd_cnt_q  <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_q     <= err_d;
    end
  end

  // Bank storage; cleared on reset so m_data reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '{default: '0};
    end else if (wr_en) begin
      bank_q[wr_bank_q][wr_cnt_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Self-checking bench for inv_shift_rows_stream. The reference model treats
// each block as a 4x4 matrix and rotates row r right by r positions.
module tb_inv_shift_rows_stream;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       err;

  inv_shift_rows_stream #(.LAST_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] in_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  int err_cnt, gap_cnt, sready_low, stable_viol, acc_cnt, acc_at_hold;
  int last_in_cyc, first_mv_cyc, timed_out;

  typedef logic [7:0] blk_t [16];

  // Expected output of one block: row r of the 4x4 state rotated right by r.
  function automatic void model_block(input blk_t blk);
    logic [7:0] st [4][4];
    logic [7:0] sh [4][4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[r][c] = blk[4*c + r];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) sh[r][(c + r) % 4] = st[r][c];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) exp_q.push_back({(c == 3 && r == 3), sh[r][c]});
  endfunction

  function automatic void feed_block(input blk_t blk);
    for (int i = 0; i < 16; i++) in_q.push_back({(i == 15), blk[i]});
  endfunction

  function automatic blk_t rand_block();
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    return b;
  endfunction

  // Drives in_q into the DUT and records accepted output bytes into got_q.
  task automatic drive(input int target, input int vpct, input int rpct,
                       input int hold, input int budget);
    int cyc;
    bit seen_mv, prev_stall, done;
    logic [8:0] prev_out;
    got_q.delete();
    err_cnt = 0; gap_cnt = 0; sready_low = 0; stable_viol = 0; acc_cnt = 0;
    acc_at_hold = 0; last_in_cyc = -1; first_mv_cyc = -1; timed_out = 0;
    cyc = 0; seen_mv = 0; prev_stall = 0; done = 0; prev_out = '0;
    while (!done) begin
      @(posedge clk); #1;
      if (in_q.size() > 0 && $urandom_range(99) < vpct) begin
        s_valid = 1'b1;
        {s_last, s_data} = in_q[0];
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'($urandom);
      end
      m_ready = (cyc >= hold) && ($urandom_range(99) < rpct);
      @(negedge clk);
      if (err) err_cnt++;
      if (!s_ready) sready_low++;
      if (prev_stall && {m_last, m_data} !== prev_out) stable_viol++;
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_last, m_data};
      if (m_valid && !seen_mv) begin
        seen_mv = 1; first_mv_cyc = cyc;
      end else if (seen_mv && !m_valid && got_q.size() < target) begin
        gap_cnt++;
      end
      if (s_valid && s_ready) begin
        void'(in_q.pop_front());
        acc_cnt++;
        last_in_cyc = cyc;
      end
      if (m_valid && m_ready) got_q.push_back({m_last, m_data});
      if (cyc == hold - 1) acc_at_hold = acc_cnt;
      cyc++;
      if (in_q.size() == 0 && got_q.size() >= target) done = 1;
      if (cyc >= budget) begin timed_out = 1; done = 1; end
    end
    repeat (2) begin
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
      @(negedge clk);
      if (err) err_cnt++;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else n_pass++;
    n_checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got %b want 1", s_ready); else n_pass++;
    n_checks++; if (m_last !== 1'b0) $display("FAIL reset_m_last got %b want 0", m_last); else n_pass++;
    n_checks++; if (m_data !== 8'h00) $display("FAIL reset_m_data got %h want 00", m_data); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
  endtask

  task automatic test_perm_order();
    logic [7:0] ord [16];
    ord = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
            8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    in_q.delete();
    for (int i = 0; i < 16; i++) in_q.push_back({(i == 15), 8'(i)});
    drive(16, 100, 100, 0, 200);
    n_checks++; if (timed_out != 0) $display("FAIL perm_timeout got %0d want 0", timed_out); else n_pass++;
    n_checks++; if (got_q.size() != 16) $display("FAIL perm_count got %0d want 16", got_q.size()); else n_pass++;
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== {(i == 15), ord[i]})
        $display("FAIL perm_byte%0d got %h want %h", i, got_q[i], {(i == 15), ord[i]});
      else n_pass++;
    end
    n_checks++;
    if (first_mv_cyc != last_in_cyc + 1)
      $display("FAIL perm_latency got %0d want %0d", first_mv_cyc, last_in_cyc + 1);
    else n_pass++;
    n_checks++; if (err_cnt != 0) $display("FAIL perm_err got %0d want 0", err_cnt); else n_pass++;
  endtask

  task automatic test_round_trip();
    blk_t u, fw;
    logic [7:0] st [4][4];
    u = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
          8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[r][c] = u[4*c + r];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) fw[4*c + r] = st[r][(c + r) % 4];
    in_q.delete();
    feed_block(fw);
    drive(16, 100, 100, 0, 200);
    n_checks++; if (got_q.size() != 16) $display("FAIL rt_count got %0d want 16", got_q.size()); else n_pass++;
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i][7:0] !== u[i]) $display("FAIL rt_byte%0d got %h want %h", i, got_q[i][7:0], u[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    in_q.delete(); exp_q.delete();
    repeat (4) begin
      blk_t b;
      b = rand_block();
      feed_block(b);
      model_block(b);
    end
    drive(64, 100, 100, 0, 300);
    n_checks++; if (got_q.size() != 64) $display("FAIL b2b_count got %0d want 64", got_q.size()); else n_pass++;
    for (int i = 0; i < 64 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL b2b_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (gap_cnt != 0) $display("FAIL b2b_gaps got %0d want 0", gap_cnt); else n_pass++;
    n_checks++; if (sready_low != 0) $display("FAIL b2b_sready_low got %0d want 0", sready_low); else n_pass++;
  endtask

  task automatic test_backpressure();
    in_q.delete(); exp_q.delete();
    repeat (3) begin
      blk_t b;
      b = rand_block();
      feed_block(b);
      model_block(b);
    end
    drive(48, 100, 100, 40, 400);
    n_checks++; if (timed_out != 0) $display("FAIL bp_timeout got %0d want 0", timed_out); else n_pass++;
    n_checks++; if (acc_at_hold != 32) $display("FAIL bp_accepted got %0d want 32", acc_at_hold); else n_pass++;
    n_checks++; if (sready_low == 0) $display("FAIL bp_sready_drop got %0d want >0", sready_low); else n_pass++;
    n_checks++; if (stable_viol != 0) $display("FAIL bp_stable got %0d want 0", stable_viol); else n_pass++;
    n_checks++; if (got_q.size() != 48) $display("FAIL bp_count got %0d want 48", got_q.size()); else n_pass++;
    for (int i = 0; i < 48 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL bp_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_framing();
    blk_t a, b;
    in_q.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) in_q.push_back({(i == 9), 8'($urandom)});
    for (int i = 0; i < 16; i++) a[i] = 8'hA0 + 8'(i);
    feed_block(a);
    model_block(a);
    for (int i = 0; i < 16; i++) in_q.push_back({1'b0, 8'($urandom)});
    b = rand_block();
    feed_block(b);
    model_block(b);
    drive(32, 100, 100, 0, 400);
    n_checks++; if (err_cnt != 2) $display("FAIL frame_err_pulses got %0d want 2", err_cnt); else n_pass++;
    n_checks++; if (got_q.size() != 32) $display("FAIL frame_count got %0d want 32", got_q.size()); else n_pass++;
    for (int i = 0; i < 32 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL frame_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    blk_t b1, b3;
    in_q.delete(); exp_q.delete();
    b1 = rand_block();
    feed_block(b1);
    model_block(b1);
    for (int i = 0; i < 7; i++) in_q.push_back({1'b0, 8'($urandom)});
    drive(8, 100, 100, 0, 200);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL mr_pre_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL mr_m_valid got %b want 0", m_valid); else n_pass++;
    n_checks++; if (s_ready !== 1'b1) $display("FAIL mr_s_ready got %b want 1", s_ready); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL mr_err got %b want 0", err); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_q.delete(); exp_q.delete();
    b3 = rand_block();
    feed_block(b3);
    model_block(b3);
    drive(16, 100, 100, 0, 200);
    n_checks++; if (got_q.size() != 16) $display("FAIL mr_post_count got %0d want 16", got_q.size()); else n_pass++;
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL mr_post_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random_traffic();
    in_q.delete(); exp_q.delete();
    repeat (6) begin
      blk_t b;
      b = rand_block();
      feed_block(b);
      model_block(b);
    end
    drive(96, 60, 55, 0, 3000);
    n_checks++; if (timed_out != 0) $display("FAIL rnd_timeout got %0d want 0", timed_out); else n_pass++;
    n_checks++; if (stable_viol != 0) $display("FAIL rnd_stable got %0d want 0", stable_viol); else n_pass++;
    n_checks++; if (got_q.size() != 96) $display("FAIL rnd_count got %0d want 96", got_q.size()); else n_pass++;
    for (int i = 0; i < 96 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL rnd_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_perm_order();
    test_round_trip();
    test_back_to_back();
    test_backpressure();
    test_framing();
    test_mid_reset();
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
